// File: rtl/crc_tx_arbiter_if.sv
// Request/transmitter bundle for crc_tx_arbiter: two request sources in,
// one CRC transmitter launch port out, plus status.
interface crc_tx_arbiter_if;
  logic         req0_start;
  logic [127:0] req0_data;
  logic [3:0]   req0_len;
  logic [1:0]   req0_dest;
  logic         req1_start;
  logic [127:0] req1_data;
  logic [3:0]   req1_len;
  logic [1:0]   req1_dest;
  logic         tx_busy;
  logic         tx_done;
  logic         tx_start;
  logic [127:0] tx_data;
  logic [3:0]   tx_len;
  logic [1:0]   tx_dest_id;
  logic         grant_id;
  logic [1:0]   pend;
  logic [7:0]   drop_cnt;
  logic         timeout_err;

  modport slave (
    input  req0_start, req0_data, req0_len, req0_dest,
    input  req1_start, req1_data, req1_len, req1_dest,
    input  tx_busy, tx_done,
    output tx_start, tx_data, tx_len, tx_dest_id,
    output grant_id, pend, drop_cnt, timeout_err
  );

  modport master (
    output req0_start, req0_data, req0_len, req0_dest,
    output req1_start, req1_data, req1_len, req1_dest,
    output tx_busy, tx_done,
    input  tx_start, tx_data, tx_len, tx_dest_id,
    input  grant_id, pend, drop_cnt, timeout_err
  );
endinterface

// File: rtl/crc_tx_arbiter.sv
// Round-robin sharing of one CRC packet transmitter between local sends (slot 0)
// and loopback echoes (slot 1); each source has a one-entry holding slot.
module crc_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input logic             clk,
  input logic             rst_n,
  crc_tx_arbiter_if.slave bus
);
  localparam int NUM_SLOTS = 2;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   len;
    logic [1:0]   dest;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  req_t [NUM_SLOTS-1:0]  w_req, r_slot;
  logic [NUM_SLOTS-1:0]  w_start, w_free, w_load, w_drop, r_pend;
  logic                  w_gnt, w_go, w_tmo;
  logic                  r_last_grant, r_grant_id, r_tx_start, r_timeout_err;
  logic [127:0]          r_tx_data;
  logic [3:0]            r_tx_len;
  logic [1:0]            r_tx_dest;
  logic [15:0]           r_cnt;
  logic [7:0]            r_drop_cnt;
  logic [8:0]            w_drop_sum;

  assign w_req[0] = {bus.req0_data, bus.req0_len, bus.req0_dest};
  assign w_req[1] = {bus.req1_data, bus.req1_len, bus.req1_dest};
  assign w_start  = {bus.req1_start, bus.req0_start};

  // A slot launching this cycle may be reloaded in the same cycle.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign w_free[s] = (r_state == S_LAUNCH) && (r_grant_id == 1'(s));
    assign w_load[s] = w_start[s] && (w_req[s].len != 4'd0) && (!r_pend[s] || w_free[s]);
    assign w_drop[s] = w_start[s] && (w_req[s].len != 4'd0) && r_pend[s] && !w_free[s];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_slot <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_load[s]) begin
          r_pend[s] <= 1'b1;
          r_slot[s] <= w_req[s];
        end else if (w_free[s]) begin
          r_pend[s] <= 1'b0;
        end
      end
    end
  end

  assign w_gnt      = (&r_pend) ? ~r_last_grant : r_pend[1];
  assign w_go       = (r_state == S_IDLE) && (w_state_nxt == S_LAUNCH);
  assign w_tmo      = (r_state == S_WAIT) && !bus.tx_done && (r_cnt == TIMEOUT_CYCLES);
  assign w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drop[0]) + 9'(w_drop[1]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!bus.tx_busy && (|r_pend)) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (bus.tx_done || (r_cnt == TIMEOUT_CYCLES)) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_grant_id    <= 1'b0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tx_data     <= '0;
      r_tx_len      <= '0;
      r_tx_dest     <= '0;
      r_cnt         <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_start    <= (r_state == S_LAUNCH);
      r_timeout_err <= w_tmo;
      r_drop_cnt    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      if (w_go) begin
        r_tx_data    <= r_slot[w_gnt].data;
        r_tx_len     <= r_slot[w_gnt].len;
        r_tx_dest    <= r_slot[w_gnt].dest;
        r_grant_id   <= w_gnt;
        r_last_grant <= w_gnt;
      end
      if (r_state == S_LAUNCH)    r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.tx_start    = r_tx_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_len      = r_tx_len;
  assign bus.tx_dest_id  = r_tx_dest;
  assign bus.grant_id    = r_grant_id;
  assign bus.pend        = r_pend;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_crc_tx_arbiter.sv
// Directed bench for crc_tx_arbiter: expected launches are queued as requests are
// driven and popped when tx_start is seen; inputs driven and outputs sampled on negedge.
module tb_crc_tx_arbiter;
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   len;
    logic [1:0]   dest;
    logic         slot;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  crc_tx_arbiter_if bus();
  crc_tx_arbiter #(.TIMEOUT_CYCLES(16'd10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive0(input logic [127:0] d, input logic [3:0] l, input logic [1:0] ds);
    bus.req0_start = 1'b1; bus.req0_data = d; bus.req0_len = l; bus.req0_dest = ds;
  endtask

  task automatic drive1(input logic [127:0] d, input logic [3:0] l, input logic [1:0] ds);
    bus.req1_start = 1'b1; bus.req1_data = d; bus.req1_len = l; bus.req1_dest = ds;
  endtask

  task automatic rel();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
  endtask

  task automatic done_pulse();
    bus.tx_done = 1'b1;
    cyc(1);
    bus.tx_done = 1'b0;
  endtask

  // Waits (bounded) for tx_start, checks latency and pops the expected launch.
  task automatic launch_chk(input string tag, input int exp_cyc);
    int   n = 0;
    exp_t e = '0;
    while (bus.tx_start !== 1'b1 && n <= exp_cyc + 4) begin
      cyc(1);
      n++;
    end
    chk({tag, ".lat"}, 128'(n), 128'(exp_cyc));
    chk({tag, ".sb"}, 128'(sb.size() > 0), 128'd1);
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, ".data"}, bus.tx_data, e.data);
    chk({tag, ".len"}, 128'(bus.tx_len), 128'(e.len));
    chk({tag, ".dest"}, 128'(bus.tx_dest_id), 128'(e.dest));
    chk({tag, ".gid"}, 128'(bus.grant_id), 128'(e.slot));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".start"}, 128'(bus.tx_start), 128'd0);
    chk({tag, ".data"}, bus.tx_data, 128'd0);
    chk({tag, ".len"}, 128'(bus.tx_len), 128'd0);
    chk({tag, ".dest"}, 128'(bus.tx_dest_id), 128'd0);
    chk({tag, ".gid"}, 128'(bus.grant_id), 128'd0);
    chk({tag, ".pend"}, 128'(bus.pend), 128'd0);
    chk({tag, ".drop"}, 128'(bus.drop_cnt), 128'd0);
    chk({tag, ".terr"}, 128'(bus.timeout_err), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d_a5;
    int n;
    int seen;
    d_a5 = {32'hA5, 96'd0};
    bus.req0_start = 1'b0; bus.req0_data = '0; bus.req0_len = '0; bus.req0_dest = '0;
    bus.req1_start = 1'b0; bus.req1_data = '0; bus.req1_len = '0; bus.req1_dest = '0;
    bus.tx_busy = 1'b0; bus.tx_done = 1'b0;

    // Reset values
    cyc(2);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    cyc(1);

    // Contention from reset: slot 0 wins, slot 1 three cycles after tx_done
    drive0(128'h1111, 4'd8, 2'd1);
    drive1(128'h2222, 4'd12, 2'd3);
    sb.push_back('{128'h1111, 4'd8, 2'd1, 1'b0});
    sb.push_back('{128'h2222, 4'd12, 2'd3, 1'b1});
    cyc(1); rel();
    chk("con.pend", 128'(bus.pend), 128'h3);
    launch_chk("con.first", 2);
    chk("con.pend2", 128'(bus.pend), 128'h2);
    cyc(2);
    done_pulse();
    launch_chk("con.second", 2);
    cyc(2);
    done_pulse();
    chk("con.pend3", 128'(bus.pend), 128'h0);

    // Single send
    drive0(d_a5, 4'd4, 2'd2);
    sb.push_back('{d_a5, 4'd4, 2'd2, 1'b0});
    cyc(1); rel();
    chk("one.pend", 128'(bus.pend), 128'h1);
    launch_chk("one", 2);
    cyc(1);
    chk("one.pulse", 128'(bus.tx_start), 128'd0);
    chk("one.pend0", 128'(bus.pend), 128'h0);
    cyc(6);
    done_pulse();
    chk("one.terr", 128'(bus.timeout_err), 128'd0);
    chk("one.hold", bus.tx_data, d_a5);

    // Repeat pair after a slot-0 launch: slot 1 first
    drive0(128'h3333, 4'd3, 2'd0);
    drive1(128'h4444, 4'd15, 2'd1);
    sb.push_back('{128'h4444, 4'd15, 2'd1, 1'b1});
    sb.push_back('{128'h3333, 4'd3, 2'd0, 1'b0});
    cyc(1); rel();
    launch_chk("rep.first", 2);
    done_pulse();
    launch_chk("rep.second", 2);
    done_pulse();
    chk("rep.drop", 128'(bus.drop_cnt), 128'd0);

    // Overflow, zero length and busy gating
    bus.tx_busy = 1'b1;
    drive1(128'h5555, 4'd5, 2'd2);
    cyc(1); rel(); cyc(1);
    chk("ovf.pend", 128'(bus.pend), 128'h2);
    for (int i = 0; i < 3; i++) begin
      drive1(128'hDEAD, 4'd7, 2'd0);
      cyc(1); rel(); cyc(1);
    end
    chk("ovf.drop3", 128'(bus.drop_cnt), 128'd3);
    drive0(128'hBEEF, 4'd0, 2'd1);
    cyc(1); rel(); cyc(1);
    chk("zlen.pend", 128'(bus.pend), 128'h2);
    chk("zlen.drop", 128'(bus.drop_cnt), 128'd3);
    drive0(128'h6666, 4'd9, 2'd3);
    cyc(1); rel();
    seen = 0;
    repeat (6) begin
      cyc(1);
      if (bus.tx_start === 1'b1) seen++;
    end
    chk("busy.gate", 128'(seen), 128'd0);
    bus.tx_busy = 1'b0;
    sb.push_back('{128'h5555, 4'd5, 2'd2, 1'b1});
    sb.push_back('{128'h6666, 4'd9, 2'd3, 1'b0});
    launch_chk("busy.rel", 2);

    // Timeout: counter reaches 10, error one cycle later with return to IDLE
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    chk("tmo.lat", 128'(n), 128'd11);
    cyc(1);
    chk("tmo.pulse", 128'(bus.timeout_err), 128'd0);
    launch_chk("tmo.next", 1);
    // tx_done in the timeout cycle beats the error
    cyc(10);
    done_pulse();
    chk("tmo.done1", 128'(bus.timeout_err), 128'd0);
    cyc(1);
    chk("tmo.done2", 128'(bus.timeout_err), 128'd0);
    chk("tmo.pend", 128'(bus.pend), 128'h0);

    // Drop counter saturation, including the +2 step across 255
    bus.tx_busy = 1'b1;
    drive0(128'h7070, 4'd1, 2'd1);
    drive1(128'h7171, 4'd2, 2'd2);
    cyc(1); rel(); cyc(1);
    chk("sat.pend", 128'(bus.pend), 128'h3);
    drive0(128'h1, 4'd1, 2'd0);
    drive1(128'h1, 4'd1, 2'd0);
    cyc(1); rel(); cyc(1);
    chk("sat.both", 128'(bus.drop_cnt), 128'd5);
    drive1(128'h1, 4'd1, 2'd0);
    cyc(249); rel(); cyc(1);
    chk("sat.254", 128'(bus.drop_cnt), 128'd254);
    drive0(128'h1, 4'd1, 2'd0);
    drive1(128'h1, 4'd1, 2'd0);
    cyc(1); rel(); cyc(1);
    chk("sat.255", 128'(bus.drop_cnt), 128'd255);
    drive0(128'h1, 4'd1, 2'd0);
    drive1(128'h1, 4'd1, 2'd0);
    cyc(300); rel(); cyc(1);
    chk("sat.hold", 128'(bus.drop_cnt), 128'd255);

    // Reset in WAIT_DONE with both slots pending
    bus.tx_busy = 1'b0;
    sb.push_back('{128'h7171, 4'd2, 2'd2, 1'b1});
    launch_chk("mid.launch", 2);
    cyc(1);
    drive1(128'h8888, 4'd6, 2'd1);
    cyc(1); rel();
    chk("mid.pend", 128'(bus.pend), 128'h3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid.rst");
    sb.delete();
    cyc(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      cyc(1);
      if (bus.tx_start === 1'b1) seen++;
    end
    chk("mid.quiet", 128'(seen), 128'd0);
    chk("mid.pend0", 128'(bus.pend), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
